// File: rtl/db_array.sv
// N-channel push-button debouncer: synchroniser, tick-gated stability filter,
// single-cycle rise/fall pulses, toggle outputs and a shared sample prescaler.
module db_array #(
  parameter int CHANNELS     = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_TICKS = 4,
  parameter int TICK_DIV     = 1,
  parameter int CNT_W        = $clog2(STABLE_TICKS + 1),
  parameter int DIV_W        = $clog2(TICK_DIV + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] btn,
  input  logic                tgl_clr,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] toggle,
  output logic                changed
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_TICKS - 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0]    div_reg;
  logic                tick;
  logic [CHANNELS-1:0] sync_reg [SYNC_STAGES];
  logic [CHANNELS-1:0] s;
  logic [CNT_W-1:0]    cnt_reg  [CHANNELS];
  logic [CNT_W-1:0]    cnt_next [CHANNELS];
  logic [CHANNELS-1:0] accept;
  logic [CHANNELS-1:0] level_reg, level_next;
  logic [CHANNELS-1:0] rise_reg, rise_next;
  logic [CHANNELS-1:0] fall_reg, fall_next;
  logic [CHANNELS-1:0] toggle_reg, toggle_next;
  logic                changed_reg, changed_next;

  // With TICK_DIV=1 the counter sits at 0 == DIV_MAX, so tick is always high.
  assign tick = (div_reg == DIV_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg <= '0;
    end else begin
      div_reg <= tick ? '0 : div_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_reg[k] <= '0;
      end
    end else begin
      sync_reg[0] <= btn;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_reg[k] <= sync_reg[k-1];
      end
    end
  end

  assign s = sync_reg[SYNC_STAGES-1];

  // Any agreeing sample clears the count, so a bounce forfeits all progress.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    assign accept[gi]   = tick && (s[gi] != level_reg[gi]) && (cnt_reg[gi] == CNT_MAX);
    assign cnt_next[gi] = !tick                                   ? cnt_reg[gi] :
                          ((s[gi] == level_reg[gi]) || accept[gi]) ? '0 :
                                                                     cnt_reg[gi] + 1'b1;
  end

  assign level_next   = level_reg ^ accept;
  assign rise_next    = accept & s;
  assign fall_next    = accept & ~s;
  assign toggle_next  = tgl_clr ? '0 : (toggle_reg ^ rise_next);
  assign changed_next = |accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_reg[i] <= '0;
      end
      level_reg   <= '0;
      rise_reg    <= '0;
      fall_reg    <= '0;
      toggle_reg  <= '0;
      changed_reg <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_reg[i] <= cnt_next[i];
      end
      level_reg   <= level_next;
      rise_reg    <= rise_next;
      fall_reg    <= fall_next;
      toggle_reg  <= toggle_next;
      changed_reg <= changed_next;
    end
  end

  assign level   = level_reg;
  assign rise    = rise_reg;
  assign fall    = fall_reg;
  assign toggle  = toggle_reg;
  assign changed = changed_reg;

endmodule

// File: tb/tb_db_array.sv
// Directed bench for db_array: per-cycle vector table on the default build,
// hand sequences on a TICK_DIV=3 / STABLE_TICKS=2 build.
module tb_db_array;

  logic clk = 1'b0;
  always #2 clk = ~clk;

  logic       rst_n, tgl_clr;
  logic [3:0] btn, level, rise, fall, toggle;
  logic       changed;

  db_array dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .tgl_clr(tgl_clr),
    .level(level), .rise(rise), .fall(fall), .toggle(toggle), .changed(changed)
  );

  logic       rst3_n, clr3, changed3;
  logic [0:0] btn3, level3, rise3, fall3, toggle3;

  db_array #(.CHANNELS(1), .SYNC_STAGES(2), .STABLE_TICKS(2), .TICK_DIV(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .btn(btn3), .tgl_clr(clr3),
    .level(level3), .rise(rise3), .fall(fall3), .toggle(toggle3), .changed(changed3)
  );

  typedef struct {
    logic [3:0] b;
    logic       clr;
    int         n;
    logic [3:0] lvl, ris, fal, tog;
    logic       chg;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passes = 0;

  task automatic add(input logic [3:0] b, input logic clr, input int n,
                     input logic [3:0] lvl, input logic [3:0] ris,
                     input logic [3:0] fal, input logic [3:0] tog, input logic chg);
    vec_t v;
    v.b = b; v.clr = clr; v.n = n;
    v.lvl = lvl; v.ris = ris; v.fal = fal; v.tog = tog; v.chg = chg;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Slow build: packed as {level, rise, fall}.
  task automatic check3(input string name, input logic l, input logic r, input logic f);
    check(name, {29'd0, level3, rise3, fall3}, {29'd0, l, r, f});
  endtask

  initial begin
    rst_n = 1'b0; btn = '0; tgl_clr = 1'b0;
    rst3_n = 1'b0; btn3 = '0; clr3 = 1'b0;

    #5;
    check("reset_main", {15'd0, level, rise, fall, toggle, changed}, 32'd0);
    check3("reset_slow", 1'b0, 1'b0, 1'b0);
    #3;
    rst_n = 1'b1;

    //    btn      clr  n  level    rise     fall     toggle   chg
    add(4'b0000, 1'b0, 3, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    // clean press / release on channel 0
    add(4'b0001, 1'b0, 5, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    add(4'b0001, 1'b0, 1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1);
    add(4'b0001, 1'b0, 3, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    add(4'b0000, 1'b0, 5, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    add(4'b0000, 1'b0, 1, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 1'b1);
    add(4'b0000, 1'b0, 2, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    // bounce on channel 1, accepted 6 edges after the last transition
    add(4'b0010, 1'b0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    add(4'b0000, 1'b0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    add(4'b0010, 1'b0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    add(4'b0000, 1'b0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    add(4'b0010, 1'b0, 5, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    add(4'b0010, 1'b0, 1, 4'b0010, 4'b0010, 4'b0000, 4'b0011, 1'b1);
    add(4'b0010, 1'b0, 2, 4'b0010, 4'b0000, 4'b0000, 4'b0011, 1'b0);
    // 3-cycle glitch on channel 2 is rejected
    add(4'b0110, 1'b0, 3, 4'b0010, 4'b0000, 4'b0000, 4'b0011, 1'b0);
    add(4'b0010, 1'b0, 6, 4'b0010, 4'b0000, 4'b0000, 4'b0011, 1'b0);
    // simultaneous press on channels 0 and 3, then release everything
    add(4'b1011, 1'b0, 5, 4'b0010, 4'b0000, 4'b0000, 4'b0011, 1'b0);
    add(4'b1011, 1'b0, 1, 4'b1011, 4'b1001, 4'b0000, 4'b1010, 1'b1);
    add(4'b1011, 1'b0, 2, 4'b1011, 4'b0000, 4'b0000, 4'b1010, 1'b0);
    add(4'b0000, 1'b0, 5, 4'b1011, 4'b0000, 4'b0000, 4'b1010, 1'b0);
    add(4'b0000, 1'b0, 1, 4'b0000, 4'b0000, 4'b1011, 4'b1010, 1'b1);
    add(4'b0000, 1'b0, 2, 4'b0000, 4'b0000, 4'b0000, 4'b1010, 1'b0);
    // clear toggles, then two presses of channel 3 with clear on the second rise
    add(4'b0000, 1'b1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    add(4'b1000, 1'b0, 5, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    add(4'b1000, 1'b0, 1, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b1);
    add(4'b1000, 1'b0, 1, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 1'b0);
    add(4'b0000, 1'b0, 5, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 1'b0);
    add(4'b0000, 1'b0, 1, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 1'b1);
    add(4'b1000, 1'b0, 5, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 1'b0);
    add(4'b1000, 1'b1, 1, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 1'b1);
    add(4'b1000, 1'b0, 1, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    add(4'b0000, 1'b0, 5, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    add(4'b0000, 1'b0, 1, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 1'b1);
    add(4'b0000, 1'b0, 2, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    for (int r = 0; r < vecs.size(); r++) begin
      btn     = vecs[r].b;
      tgl_clr = vecs[r].clr;
      for (int c = 0; c < vecs[r].n; c++) begin
        step();
        check($sformatf("row%0d_cyc%0d {level,rise,fall,toggle,changed}", r, c),
              {15'd0, level, rise, fall, toggle, changed},
              {15'd0, vecs[r].lvl, vecs[r].ris, vecs[r].fal, vecs[r].tog, vecs[r].chg});
      end
      $display("row %0d btn=%b clr=%b n=%0d level=%b toggle=%b",
               r, vecs[r].b, vecs[r].clr, vecs[r].n, level, toggle);
    end
    tgl_clr = 1'b0;

    // Slow build: ticks on edges 3, 6, 9, ... after release; accept on edge 6.
    rst3_n = 1'b1;
    btn3   = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      check3($sformatf("slow_press_e%0d", e), e >= 6, e == 6, 1'b0);
    end
    $display("slow press level=%b toggle=%b", level3, toggle3);

    // 4-cycle low pulse sees only one disagreeing tick: rejected.
    btn3 = 1'b0;
    for (int e = 9; e <= 12; e++) begin
      step();
      check3($sformatf("slow_pulse_e%0d", e), 1'b1, 1'b0, 1'b0);
    end
    btn3 = 1'b1;
    for (int e = 13; e <= 20; e++) begin
      step();
      check3($sformatf("slow_pulse_e%0d", e), 1'b1, 1'b0, 1'b0);
    end
    $display("slow pulse level=%b", level3);

    // Reset with cnt=1 pending: full latency must be paid again.
    rst3_n = 1'b0;
    #1;
    check3("slow_async_reset", 1'b0, 1'b0, 1'b0);
    step();
    rst3_n = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      step();
      check3($sformatf("slow_prep_e%0d", e), 1'b0, 1'b0, 1'b0);
    end
    rst3_n = 1'b0;
    #1;
    check3("slow_midcount_reset", 1'b0, 1'b0, 1'b0);
    step();
    rst3_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      check3($sformatf("slow_rerun_e%0d", e), e >= 6, e == 6, 1'b0);
    end
    check("slow_rerun_toggle", {31'd0, toggle3}, 32'd1);
    $display("slow rerun level=%b toggle=%b", level3, toggle3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
